// File: rtl/spi_fifo_lvl.sv
// Synchronous first-word-fall-through FIFO with occupancy level, threshold flags and watermark pulse.
// Define SPI_FIFO_ERR_EN to build the sticky ovf/udf flags; otherwise they read as 0.
module spi_fifo_lvl #(
    parameter int NWORDS    = 8,
    parameter int WORD_W    = 8,
    parameter int AF_LEVEL  = 6,
    parameter int AE_LEVEL  = 1,
    parameter int OVERWRITE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      wen,
    input  logic [WORD_W-1:0]         wdata,
    input  logic                      ren,
    output logic [WORD_W-1:0]         rdata,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(NWORDS):0]   level,
    output logic                      wm_irq,
    output logic                      ovf,
    output logic                      udf,
    input  logic                      err_clr
);
    localparam int PW = $clog2(NWORDS);
    localparam logic [PW:0] FULL_LVL = NWORDS[PW:0];
    localparam logic [PW:0] AF_LVL   = AF_LEVEL[PW:0];
    localparam logic [PW:0] AE_LVL   = AE_LEVEL[PW:0];

    logic [WORD_W-1:0] mem_q [NWORDS];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]       level_q, level_d;
    logic              wm_q, wm_d;
    logic              do_wr, do_rd, ovr_wr;

    assign full         = (level_q == FULL_LVL);
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= AF_LVL);
    assign almost_empty = (level_q <= AE_LVL);
    assign level        = level_q;
    assign wm_irq       = wm_q;
    assign rdata        = mem_q[rptr_q];

    always_comb begin
        do_rd   = ren && !empty;
        do_wr   = wen && (!full || ren || (OVERWRITE != 0));
        ovr_wr  = do_wr && full && !ren;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (do_wr)
                wptr_d = wptr_q + 1'b1;
            // an overwrite discards the oldest word by advancing the read side too
            if (do_rd || ovr_wr)
                rptr_d = rptr_q + 1'b1;
            if (do_wr && !do_rd && !full)
                level_d = level_q + 1'b1;
            else if (do_rd && !do_wr)
                level_d = level_q - 1'b1;
        end
        wm_d = !clr && (level_q < AF_LVL) && (level_d >= AF_LVL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            wm_q    <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            wm_q    <= wm_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr && do_wr)
            mem_q[wptr_q] <= wdata;
    end

`ifdef SPI_FIFO_ERR_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    always_comb begin
        ovf_d = (!clr && wen && full && !ren) || (ovf_q && !err_clr);
        udf_d = (!clr && ren && empty) || (udf_q && !err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule

// File: doc/spi_fifo_lvl.md
# spi_fifo_lvl

Parametrised synchronous FIFO for the SPI datapath, the next generation of the SPI RX/TX buffer. It adds an occupancy count, programmable almost-full/almost-empty thresholds, a watermark pulse, an optional overwrite-oldest mode and sticky overflow/underflow flags. It sits between the SPI shift engine (write side) and the bus-facing SPI register block (read side), with both sides in the `clk` domain.

## Interface
- `NWORDS`, default 8: depth in words. Must be a power of two, ≥2.
- `WORD_W`, default 8: word width in bits.
- `AF_LEVEL`, default 6: `almost_full` asserts when `level` ≥ this value. Range 1..NWORDS.
- `AE_LEVEL`, default 1: `almost_empty` asserts when `level` ≤ this value. Range 0..NWORDS-1.
- `OVERWRITE`, default 0: 0 drops a write to a full FIFO; 1 overwrites the oldest word.

Ports (PW = $clog2(NWORDS)):
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `clr`, in, 1: synchronous flush.
- `wen`, in, 1: write request.
- `wdata`, in, WORD_W: write data.
- `ren`, in, 1: read/pop request.
- `rdata`, out, WORD_W: head word (first-word fall-through).
- `full`, out, 1: `level` == NWORDS.
- `empty`, out, 1: `level` == 0.
- `almost_full`, out, 1: threshold flag.
- `almost_empty`, out, 1: threshold flag.
- `level`, out, PW+1: occupancy count, 0..NWORDS.
- `wm_irq`, out, 1: one-cycle pulse on an upward crossing of `AF_LEVEL`.
- `ovf`, out, 1: sticky overflow flag.
- `udf`, out, 1: sticky underflow flag.
- `err_clr`, in, 1: clears `ovf` and `udf`.

## Operation
- **Storage:** `mem[NWORDS]` (not reset), write pointer `wptr` and read pointer `rptr` (PW bits, natural wrap at NWORDS-1→0), and a registered `level`.
- **Flags:** `full`, `empty`, `almost_full` and `almost_empty` are decoded from `level` only. `rdata` = `mem[rptr]`, valid only when `!empty`.
- **Priority:** `rst` > `clr` > normal operation. `clr` zeroes `wptr`, `rptr` and `level`. It does not touch `ovf`/`udf`. Any `wen`/`ren` in the same cycle is ignored.
- **Write accepted when:** `!full`; or `full & ren`; or `full & OVERWRITE`.
- **Read accepted when:** `!empty`. A read on an empty FIFO is ignored, even if a simultaneous write is accepted.
- **Level update:**
  - Write only: `level`+1.
  - Read only: `level`-1.
  - Both: unchanged.
  - Overwrite write (`full`, `!ren`, `OVERWRITE`=1): `wptr`+1 and `rptr`+1, `level` stays NWORDS, and the oldest word is lost.
- **Dropped write** (`full`, `!ren`, `OVERWRITE`=0): pointers and memory unchanged.
- **Error events:**
  - Overflow event: `wen & full & !ren`, whether the write is dropped or overwrites.
  - Underflow event: `ren & empty`.
- **`wm_irq`:** asserts for exactly one cycle after a clock edge where `level` goes from < `AF_LEVEL` to ≥ `AF_LEVEL`. A `clr` never generates it.

## Timing
- **Reset values:**
  - `level`: 0.
  - `empty`: 1.
  - `full`: 0.
  - `almost_empty`: 1.
  - `almost_full`: 0.
  - `wm_irq`, `ovf`, `udf`: 0.
  - `rdata`: undefined.
- **Write-to-read latency:** 1 cycle. A word written at edge N appears on `rdata` and deasserts `empty` after edge N.
- **Pop:** `ren` sampled at edge N advances `rdata` to the next word after edge N. The consumer samples `rdata` in the same cycle it asserts `ren`.
- **Output timing:** `level` and all four status flags update on the same edge as the pointers. There is no combinational path from `wen`/`ren` to any status output.
- **Full throughput:** simultaneous `wen & ren` sustains one word per cycle at any level, including full and at pointer wrap.
- **Sticky flags:** `ovf`/`udf` set on the edge after the event. `err_clr` clears them on the next edge. If an event and `err_clr` occur in the same cycle, set wins.
- **Mid-operation reset:** `rst` asserted mid-operation returns all outputs to reset values immediately, independent of `clk`.

## Configuration
- Macro `SPI_FIFO_ERR_EN`.
- **Defined:** `ovf`/`udf` behave as above, and `err_clr` is honoured.
- **Undefined:** `ovf` and `udf` are tied to 0, `err_clr` is ignored, and the flag registers are not built. The port list is unchanged and all other behaviour is identical.

## Test plan
- **Reset and fill** (NWORDS=8, AF_LEVEL=6): reset, then write 0x01..0x08 on consecutive cycles.
  - `level` counts 1..8.
  - `wm_irq` pulses once, the cycle `level` reaches 6.
  - `full`=1 after the 8th write. `rdata`=0x01 throughout.
- **Drain** (same config): from full, read 8 times.
  - `rdata` sequence is 0x01..0x08.
  - `almost_empty` rises at `level`=1. `empty`=1 after the 8th pop.
  - A 9th `ren` sets `udf`, and `level` stays 0.
- **Full drop** (OVERWRITE=0): at full, write 0xAA.
  - `ovf`=1, `level`=8, and the memory is unchanged (drain still gives 0x01..0x08).
  - `err_clr` then returns `ovf` to 0.
- **Full overwrite** (OVERWRITE=1): at full with 0x01..0x08, write 0xAA.
  - `ovf`=1, `level`=8, and the drain sequence is 0x02..0x08, 0xAA.
- **Simultaneous access:**
  - At full, hold `wen`+`ren` for 20 cycles with incrementing data. `level` stays 8, with no `ovf`, and `rdata` is in order across the pointer wrap.
  - At empty, one `wen`+`ren`. `level`=1 and `udf`=1.
- **Flush and async reset:**
  - At `level`=5, assert `clr` together with `wen`. Result: `level`=0, `empty`=1, no `wm_irq`, and `ovf`/`udf` retained.
  - Assert `rst` between clock edges. All outputs return to reset values before the next edge.
